// File: rtl/mdu_ctrl.sv
// Execute-stage controller for the RV32M multiply/divide unit: resolves divide
// corner cases locally, otherwise launches the op on muldiv and holds the result for writeback.
module mdu_ctrl #(
  parameter int RD_W     = 5,
  parameter int FAST_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_func3,
  input  logic [31:0]     in_rs1,
  input  logic [31:0]     in_rs2,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            md_valid,
  output logic [2:0]      md_op,
  output logic [31:0]     md_op1,
  output logic [31:0]     md_op2,
  output logic            md_stall,
  input  logic            md_ready,
  input  logic [31:0]     md_out,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} state_t;

  state_t      state;
  logic        accept;
  logic        div_zero;
  logic        div_ovf;
  logic        fast_hit;
  logic [31:0] fast_data;

  assign md_stall = 1'b0;
  assign in_ready = ~flush & ((state == IDLE) | ((state == WB) & wb_ready));
  assign accept   = in_valid & in_ready;

  // func3[2] selects divide/remainder, func3[1] remainder, func3[0] unsigned.
  assign div_zero = (in_rs2 == 32'd0);
  assign div_ovf  = ~in_func3[0] & (in_rs1 == 32'h8000_0000) & (in_rs2 == 32'hFFFF_FFFF);
  assign fast_hit = (FAST_DIV != 0) & in_func3[2] & (div_zero | div_ovf);

  always_comb begin
    fast_data = 32'd0;
    if (div_zero)
      fast_data = in_func3[1] ? in_rs1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      fast_data = in_func3[1] ? 32'd0 : 32'h8000_0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      md_valid <= 1'b0;
      md_op    <= 3'd0;
      md_op1   <= 32'd0;
      md_op2   <= 32'd0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= 32'd0;
      busy     <= 1'b0;
    end else if (accept) begin
      // Accept only happens from IDLE or a retiring WB, so this covers both.
      md_op  <= in_func3;
      md_op1 <= in_rs1;
      md_op2 <= in_rs2;
      wb_rd  <= in_rd;
      busy   <= 1'b1;
      if (fast_hit) begin
        state    <= WB;
        md_valid <= 1'b0;
        wb_valid <= 1'b1;
        wb_data  <= fast_data;
      end else begin
        state    <= ISSUE;
        md_valid <= 1'b1;
        wb_valid <= 1'b0;
      end
    end else begin
      case (state)
        ISSUE: begin
          if (md_ready && flush) begin
            state    <= IDLE;
            md_valid <= 1'b0;
            busy     <= 1'b0;
          end else if (md_ready) begin
            state    <= WB;
            md_valid <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= md_out;
          end else if (flush) begin
            // muldiv cannot be aborted: keep driving it until it completes.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (md_ready) begin
            state    <= IDLE;
            md_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        WB: begin
          if (flush || wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
